// File: rtl/int_root_seq_if.sv
// ============================================================================
//  Module  : int_root_seq_if
//  Brief   : Request/response bundle for the bit-serial integer root engine.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface int_root_seq_if #(
  parameter int WIDTH = 32
);
  localparam int RW = (WIDTH + 1) / 2;

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] number;
  logic             ready;
  logic             busy;
  logic             done;
  logic [RW-1:0]    root;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, mode, number,
    input  ready, busy, done, root, remainder
  );

  modport slave (
    input  start, mode, number,
    output ready, busy, done, root, remainder
  );
endinterface

`default_nettype wire

// File: rtl/int_root_seq.sv
// ============================================================================
//  Module  : int_root_seq
//  Brief   : Bit-serial floor square/cube root with remainder, one bit per clock.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module int_root_seq #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  int_root_seq_if.slave     bus
);

  localparam int RW      = (WIDTH + 1) / 2;
  localparam int PW      = 3 * RW;
  localparam int BW      = (RW > 1) ? $clog2(RW) : 1;
  localparam int ITER_SQ = RW;
  localparam int ITER_CB = (WIDTH + 2) / 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             mode_q, mode_d;
  logic [RW-1:0]    part_q, part_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [RW-1:0]    root_q, root_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [RW-1:0]    cand;
  logic [PW-1:0]    cand_pow;
  logic [PW-1:0]    num_ext;
  logic             take;
  logic [RW-1:0]    next_part;
  logic [PW-1:0]    next_pow;

  // PW = 3*RW holds any RW-bit value cubed, so compares never overflow.
  function automatic logic [PW-1:0] power(input logic [RW-1:0] x, input logic cube);
    logic [PW-1:0] xe;
    logic [PW-1:0] sq;
    xe = PW'(x);
    sq = xe * xe;
    return cube ? (sq * xe) : sq;
  endfunction

  always_comb begin
    cand      = part_q | (RW'(1) << bit_q);
    cand_pow  = power(cand, mode_q);
    num_ext   = PW'(num_q);
    take      = (cand_pow <= num_ext);
    next_part = take ? cand : part_q;
    next_pow  = power(next_part, mode_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      mode_q  <= 1'b0;
      part_q  <= '0;
      bit_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      mode_q  <= mode_d;
      part_q  <= part_d;
      bit_q   <= bit_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    mode_d  = mode_q;
    part_d  = part_q;
    bit_d   = bit_q;
    root_d  = root_q;
    rem_d   = rem_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          num_d   = bus.number;
          mode_d  = bus.mode;
          part_d  = '0;
          bit_d   = bus.mode ? BW'(ITER_CB - 1) : BW'(ITER_SQ - 1);
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        part_d = next_part;
        if (bit_q == '0) begin
          root_d  = next_part;
          rem_d   = WIDTH'(num_ext - next_pow);
          state_d = S_DONE;
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q == S_CALC);
  assign bus.ready     = (state_q != S_CALC);
  assign bus.done      = (state_q == S_DONE);
  assign bus.root      = root_q;
  assign bus.remainder = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_int_root_seq.sv
// ============================================================================
//  Module  : tb_int_root_seq
//  Brief   : Directed and property-checked sweep for int_root_seq at WIDTH=32.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_int_root_seq;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  int_root_seq_if #(.WIDTH(WIDTH)) bus ();

  int_root_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds start for exactly one edge; returns #1 after the start edge.
  task automatic pulse_start(input logic m, input logic [WIDTH-1:0] n);
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.number = n;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  function automatic longint unsigned rpow(input longint unsigned x, input logic cube);
    return cube ? x * x * x : x * x;
  endfunction

  initial begin
    int lat;
    int bc;
    int done_seen;
    logic m;
    logic [WIDTH-1:0] n;
    longint unsigned r, p, p1;

    clk = 1'b0;
    rst = 1'b1;
    n_err = 0;
    n_chk = 0;
    bus.start  = 1'b0;
    bus.mode   = 1'b0;
    bus.number = '0;

    step();
    step();
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_root", bus.root, 0);
    check("rst_rem", bus.remainder, 0);
    rst = 1'b0;
    step();

    // sqrt(26) with latency and busy-window checks
    pulse_start(1'b0, 32'd26);
    wait_done(lat, bc);
    check("sq26_lat", lat, 16);
    check("sq26_busycnt", bc, 16);
    check("sq26_busy_at_done", bus.busy, 0);
    check("sq26_ready_at_done", bus.ready, 1);
    check("sq26_root", bus.root, 5);
    check("sq26_rem", bus.remainder, 1);
    step();
    check("sq26_done_drop", bus.done, 0);

    pulse_start(1'b0, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    check("sqmax_root", bus.root, 65535);
    check("sqmax_rem", bus.remainder, 131070);

    pulse_start(1'b0, 32'd0);
    wait_done(lat, bc);
    check("sq0_root", bus.root, 0);
    check("sq0_rem", bus.remainder, 0);

    pulse_start(1'b0, 32'd1);
    wait_done(lat, bc);
    check("sq1_root", bus.root, 1);
    check("sq1_rem", bus.remainder, 0);

    pulse_start(1'b1, 32'd27);
    wait_done(lat, bc);
    check("cb27_lat", lat, 11);
    check("cb27_root", bus.root, 3);
    check("cb27_rem", bus.remainder, 0);

    pulse_start(1'b1, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    check("cbmax_root", bus.root, 1625);
    check("cbmax_rem", bus.remainder, 3951670);

    pulse_start(1'b1, 32'd1);
    wait_done(lat, bc);
    check("cb1_root", bus.root, 1);
    check("cb1_rem", bus.remainder, 0);

    // Start during CALC must be ignored; start in DONE must be taken.
    pulse_start(1'b0, 32'd100);
    repeat (4) step();
    pulse_start(1'b1, 32'd8);
    wait_done(lat, bc);
    check("busy_ign_lat", lat + 5, 16);
    check("busy_ign_root", bus.root, 10);
    check("busy_ign_rem", bus.remainder, 0);
    pulse_start(1'b1, 32'd8);
    check("b2b_done_drop", bus.done, 0);
    check("b2b_busy", bus.busy, 1);
    check("b2b_root_hold", bus.root, 10);
    wait_done(lat, bc);
    check("b2b_lat", lat, 11);
    check("b2b_root", bus.root, 2);
    check("b2b_rem", bus.remainder, 0);

    // Reset aborts a calculation in flight.
    pulse_start(1'b0, 32'd50);
    done_seen = 0;
    repeat (4) begin
      step();
      if (bus.done) done_seen++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_ready", bus.ready, 1);
    check("abort_done", bus.done, 0);
    check("abort_root", bus.root, 0);
    check("abort_rem", bus.remainder, 0);
    repeat (16) begin
      step();
      if (bus.done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    pulse_start(1'b0, 32'd49);
    wait_done(lat, bc);
    check("post_abort_root", bus.root, 7);
    check("post_abort_rem", bus.remainder, 0);

    // Property sweep: root^k <= n < (root+1)^k and exact remainder.
    for (int i = 0; i < 1000; i++) begin
      m = i[0];
      n = ((i % 4) == 2) ? WIDTH'($urandom_range(0, 2000)) : WIDTH'($urandom);
      pulse_start(m, n);
      wait_done(lat, bc);
      r  = longint'(bus.root);
      p  = rpow(r, m);
      p1 = rpow(r + 1, m);
      check("rnd_lat", lat, m ? 11 : 16);
      check("rnd_lo", (p <= longint'(n)) ? 1 : 0, 1);
      check("rnd_hi", (p1 > longint'(n)) ? 1 : 0, 1);
      check("rnd_rem", bus.remainder, longint'(n) - p);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
